muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
Multi-cycle RV32M multiply/divide execution unit. It sits beside the single-cycle ALU in the execute stage and serves the funct3-coded M-extension operations that the combinational ALU cannot. It is a responder behind a valid/ready request channel and a valid/ready response channel. The decode/control logic is the initiator and stalls the pipeline while a request is outstanding.

Parameters:
XLEN, 32, operand and result width; only 32 is supported.

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request
req_op  input  3  operation, RV32M funct3 encoding
req_src1  input  32  rs1 operand
req_src2  input  32  rs2 operand
resp_valid  output  1  result available
resp_ready  input  1  consumer takes the result
resp_result  output  32  operation result

Behaviour:
- Reset (synchronous, active-high): state=IDLE, req_ready=1, resp_valid=0, resp_result=0, iteration counter=0, internal accumulators=0.
- req_ready is 1 only in IDLE. A request is accepted when req_valid & req_ready are both 1 at a rising edge. Operands and op are captured at that edge and not sampled again.
- States and transitions:
  - IDLE -> CALC on accept with a normal operand set.
  - IDLE -> DONE on accept with a special case.
  - CALC runs exactly 32 iterations, counter 0..31, then -> DONE.
  - DONE holds resp_valid=1 until resp_valid & resp_ready, then -> IDLE.
- Latency, accept at edge 0:
  - Normal operation: resp_valid rises after edge 33.
  - Special case: resp_valid rises after edge 1.
  - resp_ready is ignored outside DONE.
- Back-to-back: a new request is accepted no earlier than the cycle after the response handshake (no bypass). req_ready=0 throughout CALC and DONE.
- resp_result is stable while resp_valid=1. It keeps its last value after the handshake until the next result is written.
- Multiply (op 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU):
  - Operand signedness per op: MULH both signed; MULHSU src1 signed, src2 unsigned; MULHU and MUL unsigned magnitude.
  - Take the magnitudes, then do 32 shift-add steps into a 64-bit product.
  - Negate the 64-bit product if the operand signs differ.
  - MUL returns product[31:0]; the others return product[63:32].
- Divide (op 100 DIV, 101 DIVU, 110 REM, 111 REMU):
  - Restoring division on magnitudes, 32 shift-subtract steps.
  - Quotient sign = sign1 XOR sign2 (signed ops only).
  - Remainder sign = sign of src1 (signed ops only).
- Special cases, decided at accept and resolved in one cycle:
  - Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return src1.
  - Signed overflow, src1=0x80000000 and src2=0xFFFFFFFF: DIV returns 0x80000000; REM returns 0.
  - No other early-out cases exist; multiply by 0 still takes 33 cycles.
- All arithmetic wraps modulo 2^64 internally. There are no exceptions or flags.
- Reset mid-operation, in CALC or DONE: the operation is aborted and its result discarded. The next cycle is IDLE with req_ready=1 and resp_valid=0.
- Simultaneous req_valid and resp_ready in DONE: the response handshake completes and the request is not accepted that cycle.

Decomposition:
- Shared package muldiv_pkg holds:
  - the op encodings (MUL..REMU, 3-bit constants equal to RV32M funct3);
  - the state enum (IDLE, CALC, DONE);
  - the ITER_COUNT=32 constant.
- One sub-module is natural: muldiv_step. It is a combinational single-iteration datapath doing one shift-add for multiply or one shift-subtract/restore for divide, selected by a mode bit. The top level owns the FSM, counter, sign handling and final negation.

Test Plan:
- MUL 7 x 6, held resp_ready=1 -> req_ready drops after accept; resp_valid asserts after edge 33 with resp_result=0x0000002A; back to IDLE next cycle.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000. MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 0x1234/0 -> 0xFFFFFFFF and REMU 0x1234/0 -> 0x1234, each with resp_valid after edge 1. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM of the same -> 0, also 1-cycle.
- Backpressure: hold resp_ready=0 for 10 cycles in DONE -> resp_valid and resp_result stay stable and req_ready stays 0. Raising resp_ready completes the handshake.
- Assert reset at iteration 15 of a DIVU -> the next cycle shows req_ready=1, resp_valid=0, resp_result=0. A following MUL 3 x 5 returns 15 with normal latency.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op codes, FSM states,
// iteration count and small arithmetic helpers.
package muldiv_pkg;

  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = 5'(ITER_COUNT - 1);

  // Op codes equal the RV32M funct3 field.
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  // Two's-complement negation, 32 bits.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // Two's-complement negation, 64 bits.
  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath. mode_i=0: MSB-first shift-add
// multiply. mode_i=1: restoring shift-subtract divide, where acc holds the
// partial remainder and opb shifts the dividend out / quotient bits in.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic        mode_i,
  input  logic [63:0] acc_i,
  input  logic [31:0] opa_i,
  input  logic [31:0] opb_i,
  output logic [63:0] acc_o,
  output logic [31:0] opb_o
);

  logic [32:0] rem_sh_s;
  logic [33:0] diff_s;

  // Single multiply or divide iteration selected by mode_i.
  always_comb begin
    rem_sh_s = {acc_i[31:0], opb_i[31]};
    diff_s   = {1'b0, rem_sh_s} - {2'b00, opa_i};
    acc_o    = acc_i;
    opb_o    = opb_i;
    if (mode_i) begin
      // No borrow means the divisor fits: keep the difference, quotient bit 1.
      if (!diff_s[33]) begin
        acc_o = {31'd0, diff_s[32:0]};
        opb_o = {opb_i[30:0], 1'b1};
      end else begin
        acc_o = {31'd0, rem_sh_s};
        opb_o = {opb_i[30:0], 1'b0};
      end
    end else begin
      if (opb_i[31]) begin
        acc_o = (acc_i << 1) + {32'd0, opa_i};
      end else begin
        acc_o = (acc_i << 1);
      end
      opb_o = {opb_i[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit behind valid/ready request and
// response channels. Owns the FSM, iteration counter, sign handling and the
// final negation; the per-iteration arithmetic lives in muldiv_step.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_src1,
  input  logic [XLEN-1:0] req_src2,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      acc_q, acc_d;
  logic [31:0]      opa_q, opa_d;
  logic [31:0]      opb_q, opb_d;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic [31:0]      result_q, result_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;

  logic             s1_s, s2_s;
  logic [31:0]      mag1_s, mag2_s;
  logic             div_zero_s, div_ovf_s;
  logic [63:0]      step_acc_s;
  logic [31:0]      step_opb_s;
  logic [63:0]      prod_s;
  logic [31:0]      final_s;

  muldiv_step u_step (
    .mode_i (op_q[2]),
    .acc_i  (acc_q),
    .opa_i  (opa_q),
    .opb_i  (opb_q),
    .acc_o  (step_acc_s),
    .opb_o  (step_opb_s)
  );

  // Operand signs, magnitudes and early-out detection for the incoming request.
  always_comb begin
    s1_s       = 1'b0;
    s2_s       = 1'b0;
    div_zero_s = 1'b0;
    div_ovf_s  = 1'b0;
    case (req_op)
      OP_MULH, OP_DIV, OP_REM: begin
        s1_s = req_src1[31];
        s2_s = req_src2[31];
      end
      OP_MULHSU: begin
        s1_s = req_src1[31];
        s2_s = 1'b0;
      end
      default: begin
        s1_s = 1'b0;
        s2_s = 1'b0;
      end
    endcase
    mag1_s = s1_s ? neg32(req_src1) : req_src1;
    mag2_s = s2_s ? neg32(req_src2) : req_src2;
    if (req_op[2] && (req_src2 == 32'd0)) begin
      div_zero_s = 1'b1;
    end else begin
      div_zero_s = 1'b0;
    end
    if (((req_op == OP_DIV) || (req_op == OP_REM)) &&
        (req_src1 == 32'h8000_0000) && (req_src2 == 32'hFFFF_FFFF)) begin
      div_ovf_s = 1'b1;
    end else begin
      div_ovf_s = 1'b0;
    end
  end

  // Result of the last iteration with sign correction and half/part selection.
  always_comb begin
    prod_s  = neg_q ? neg64(step_acc_s) : step_acc_s;
    final_s = 32'd0;
    case (op_q)
      OP_MUL:                        final_s = prod_s[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  final_s = prod_s[63:32];
      OP_DIV, OP_DIVU:               final_s = neg_q ? neg32(step_opb_s) : step_opb_s;
      OP_REM, OP_REMU:               final_s = neg_q ? neg32(step_acc_s[31:0]) : step_acc_s[31:0];
      default:                       final_s = 32'd0;
    endcase
  end

  // FSM next state, datapath register updates and handshake outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    op_d         = op_q;
    neg_d        = neg_q;
    result_d     = result_q;
    resp_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d  = req_op;
          cnt_d = '0;
          acc_d = 64'd0;
          if (div_zero_s) begin
            result_d = req_op[1] ? req_src1 : 32'hFFFF_FFFF;
            state_d  = DONE;
          end else if (div_ovf_s) begin
            result_d = req_op[1] ? 32'd0 : 32'h8000_0000;
            state_d  = DONE;
          end else begin
            state_d = CALC;
            // Remainder follows the dividend sign; everything else the XOR.
            neg_d   = (req_op == OP_REM) ? s1_s : (s1_s ^ s2_s);
            if (req_op[2]) begin
              opa_d = mag2_s;
              opb_d = mag1_s;
            end else begin
              opa_d = mag1_s;
              opb_d = mag2_s;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d = step_acc_s;
        opb_d = step_opb_s;
        if (cnt_q == CNT_LAST) begin
          result_d = final_s;
          cnt_d    = '0;
          state_d  = DONE;
        end else begin
          cnt_d   = cnt_q + 5'd1;
          state_d = CALC;
        end
      end
      DONE: begin
        // resp_valid is raised one cycle after entering DONE.
        if (resp_valid_q && resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end else begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    req_ready_d = (state_d == IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      acc_q        <= 64'd0;
      opa_q        <= 32'd0;
      opb_q        <= 32'd0;
      op_q         <= 3'd0;
      neg_q        <= 1'b0;
      result_q     <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      op_q         <= op_d;
      neg_q        <= neg_d;
      result_q     <= result_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = result_q;

endmodule
